// File: rtl/risc_v32i.sv
// risc_v32i: single-cycle RV32I core with on-chip instruction and data memories
module risc_v32i_imem (
    input  logic        clk,
    input  logic        we_i,
    input  logic [6:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [6:0]  raddr_i,
    output logic [31:0] rdata_o
);
    logic [31:0] inst_reg [0:127];
    always_ff @(posedge clk) if (we_i) inst_reg[waddr_i] <= wdata_i;
    assign rdata_o = inst_reg[raddr_i];
endmodule

module risc_v32i_dmem (
    input  logic        clk,
    input  logic        we_i,
    input  logic [1:0]  size_i,
    input  logic [7:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o
);
    logic [7:0] MEM_Data [0:255];
    logic [7:0] a1, a2, a3;
    assign a1 = addr_i + 8'd1;
    assign a2 = addr_i + 8'd2;
    assign a3 = addr_i + 8'd3;
    assign rdata_o = {MEM_Data[a3], MEM_Data[a2], MEM_Data[a1], MEM_Data[addr_i]};
    always_ff @(posedge clk) begin
        if (we_i) begin
            MEM_Data[addr_i] <= wdata_i[7:0];
            if (size_i != 2'd0) MEM_Data[a1] <= wdata_i[15:8];
            if (size_i[1]) begin
                MEM_Data[a2] <= wdata_i[23:16];
                MEM_Data[a3] <= wdata_i[31:24];
            end
        end
    end
endmodule

module risc_v32i (
    output logic [31:0] WB_o,
    input  logic [31:0] inst_data,
    input  logic [6:0]  inst_addr,
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_wen,
    input  logic        enb
);
    localparam logic [6:0] OP_LUI = 7'h37, OP_AUIPC = 7'h17, OP_JAL = 7'h6f, OP_JALR = 7'h67;
    localparam logic [6:0] OP_BR = 7'h63, OP_LD = 7'h03, OP_ST = 7'h23, OP_IMM = 7'h13, OP_REG = 7'h33;

    logic [31:0] pc_q, pc_d, instr, rs1_v, rs2_v, imm_i, imm_b, imm_u, imm_j;
    logic [31:0] opb, alu, sra_v, ld_raw, ld_v, rd_v, pc4;
    logic [31:0] rf_q [32];
    logic [6:0]  opc;
    logic [4:0]  rd, shamt;
    logic [2:0]  f3;
    logic [7:0]  off, ea;
    logic        run, wr, cmp, take, is_st;

    risc_v32i_imem IMEM (.clk, .we_i(inst_wen), .waddr_i(inst_addr), .wdata_i(inst_data),
                         .raddr_i(pc_q[8:2]), .rdata_o(instr));

    assign opc   = instr[6:0];
    assign rd    = instr[11:7];
    assign f3    = instr[14:12];
    assign rs1_v = instr[19:15] == 5'd0 ? '0 : rf_q[instr[19:15]];
    assign rs2_v = instr[24:20] == 5'd0 ? '0 : rf_q[instr[24:20]];
    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'd0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign run   = enb && !rst;
    assign pc4   = pc_q + 32'd4;
    assign is_st = opc == OP_ST;

    // Data memory only decodes 8 address bits, so the effective address is formed on the low byte
    assign off = is_st ? {instr[27:25], instr[11:7]} : instr[27:20];
    assign ea  = rs1_v[7:0] + off;

    risc_v32i_dmem DATAMEM (.clk, .we_i(run && is_st), .size_i(f3[1:0]), .addr_i(ea),
                            .wdata_i(rs2_v), .rdata_o(ld_raw));

    assign ld_v = f3[1:0] == 2'd0 ? {{24{!f3[2] && ld_raw[7]}}, ld_raw[7:0]} :
                  f3[1:0] == 2'd1 ? {{16{!f3[2] && ld_raw[15]}}, ld_raw[15:0]} : ld_raw;

    assign opb   = opc == OP_REG ? rs2_v : imm_i;
    assign shamt = opb[4:0];
    assign sra_v = $signed(rs1_v) >>> shamt;

    always_comb begin
        case (f3)
            3'd0:    alu = (opc == OP_REG && instr[30]) ? rs1_v - opb : rs1_v + opb;
            3'd1:    alu = rs1_v << shamt;
            3'd2:    alu = {31'd0, $signed(rs1_v) < $signed(opb)};
            3'd3:    alu = {31'd0, rs1_v < opb};
            3'd4:    alu = rs1_v ^ opb;
            3'd5:    alu = instr[30] ? sra_v : rs1_v >> shamt;
            3'd6:    alu = rs1_v | opb;
            default: alu = rs1_v & opb;
        endcase
    end

    // funct3[0] inverts the base comparison; funct3 010/011 are not branches
    assign cmp  = f3[2:1] == 2'b00 ? rs1_v == rs2_v :
                  f3[1] ? rs1_v < rs2_v : $signed(rs1_v) < $signed(rs2_v);
    assign take = f3[2:1] != 2'b01 && (cmp ^ f3[0]);

    assign wr = opc == OP_LUI || opc == OP_AUIPC || opc == OP_JAL || opc == OP_JALR ||
                opc == OP_LD || opc == OP_IMM || opc == OP_REG;

    assign rd_v = opc == OP_LUI ? imm_u :
                  opc == OP_AUIPC ? pc_q + imm_u :
                  (opc == OP_JAL || opc == OP_JALR) ? pc4 :
                  opc == OP_LD ? ld_v : alu;

    assign WB_o = run && wr ? rd_v : '0;

    assign pc_d = rst ? '0 :
                  !enb ? pc_q :
                  opc == OP_JAL ? pc_q + imm_j :
                  opc == OP_JALR ? (rs1_v + imm_i) & ~32'd1 :
                  (opc == OP_BR && take) ? pc_q + imm_b : pc4;

    always_ff @(posedge clk) begin
        pc_q <= pc_d;
        if (rst) begin
            for (int i = 1; i < 32; i++) rf_q[i[4:0]] <= '0;
        end else if (run && wr && rd != 5'd0) begin
            rf_q[rd] <= rd_v;
        end
    end
endmodule

// File: tb/tb_risc_v32i.sv
// tb_risc_v32i: directed and random program checks of risc_v32i against an instruction-level model
module tb_risc_v32i;
    logic        clk = 0, rst = 1, inst_wen = 0, enb = 0;
    logic [31:0] inst_data = 0;
    logic [6:0]  inst_addr = 0;
    logic [31:0] WB_o;
    int          checks = 0, errors = 0;

    logic [31:0] m_pc;
    logic [31:0] m_x [32];
    logic [31:0] m_imem [128];
    logic [7:0]  m_mem [256];
    logic [31:0] prog [$];

    logic [31:0] bwb [10] = '{32'hFFFFFFFF, 32'd1, 32'd0, 32'h14, 32'd0, 32'd0, 32'd0, 32'h31, 32'h30, 32'd5};
    logic [31:0] bpc [10] = '{32'd4, 32'd8, 32'd16, 32'd24, 32'd28, 32'd36, 32'd40, 32'd44, 32'd48, 32'd52};

    risc_v32i dut (.WB_o(WB_o), .inst_data(inst_data), .inst_addr(inst_addr), .clk(clk),
                   .rst(rst), .inst_wen(inst_wen), .enb(enb));

    always #5 clk = ~clk;

    function automatic logic [31:0] ei(int op, int f3, int rd, int rs1, int imm);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
    endfunction
    function automatic logic [31:0] er(int f3, int f7, int rd, int rs1, int rs2);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
    endfunction
    function automatic logic [31:0] es(int f3, int rs1, int rs2, int imm);
        return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] eb(int f3, int rs1, int rs2, int imm);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] eu(int op, int rd, int imm);
        return {imm[19:0], rd[4:0], op[6:0]};
    endfunction
    function automatic logic [31:0] ej(int rd, int imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6f};
    endfunction

    function automatic logic [31:0] alu(logic [2:0] f, logic [31:0] a, logic [31:0] b, logic alt);
        logic signed [31:0] sa;
        sa = $signed(a) >>> b[4:0];
        case (f)
            3'd0: return alt ? a - b : a + b;
            3'd1: return a << b[4:0];
            3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return alt ? sa : a >> b[4:0];
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    task automatic model_step(output logic [31:0] wb);
        logic [31:0] ins, a, b, ii, is, ib, ij, iu, nxt, ea, v;
        logic [7:0]  ad;
        logic [2:0]  f3;
        logic        w, tk;
        int          n;
        ins = m_imem[m_pc[8:2]];
        f3  = ins[14:12];
        a   = m_x[ins[19:15]];
        b   = m_x[ins[24:20]];
        ii  = {{20{ins[31]}}, ins[31:20]};
        is  = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        ib  = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        ij  = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        iu  = {ins[31:12], 12'd0};
        nxt = m_pc + 4;
        wb  = 0;
        w   = 1;
        n   = f3[1:0] == 2'd0 ? 1 : f3[1:0] == 2'd1 ? 2 : 4;
        case (ins[6:0])
            7'h37: wb = iu;
            7'h17: wb = m_pc + iu;
            7'h6f: begin wb = m_pc + 4; nxt = m_pc + ij; end
            7'h67: begin wb = m_pc + 4; nxt = (a + ii) & ~32'd1; end
            7'h63: begin
                w = 0;
                case (f3)
                    3'd0: tk = a == b;
                    3'd1: tk = a != b;
                    3'd4: tk = $signed(a) < $signed(b);
                    3'd5: tk = $signed(a) >= $signed(b);
                    3'd6: tk = a < b;
                    3'd7: tk = a >= b;
                    default: tk = 0;
                endcase
                if (tk) nxt = m_pc + ib;
            end
            7'h03: begin
                ea = a + ii;
                v = 0;
                for (int j = 0; j < n; j++) begin
                    ad = ea[7:0] + 8'(j);
                    v[8*j +: 8] = m_mem[ad];
                end
                if (!f3[2] && n < 4 && v[8*n-1])
                    for (int j = 8 * n; j < 32; j++) v[j] = 1'b1;
                wb = v;
            end
            7'h23: begin
                w = 0;
                ea = a + is;
                for (int j = 0; j < n; j++) begin
                    ad = ea[7:0] + 8'(j);
                    m_mem[ad] = b[8*j +: 8];
                end
            end
            7'h13: wb = alu(f3, a, ii, f3 == 3'd5 && ins[30]);
            7'h33: wb = alu(f3, a, b, ins[30]);
            default: w = 0;
        endcase
        if (w && ins[11:7] != 5'd0) m_x[ins[11:7]] = wb;
        m_pc = nxt;
    endtask

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step_chk(string tag);
        logic [31:0] e;
        #1;
        model_step(e);
        check(tag, WB_o, e);
        @(posedge clk); #1;
    endtask

    task automatic step_k(string tag, logic [31:0] k);
        logic [31:0] e;
        #1;
        model_step(e);
        check(tag, WB_o, k);
        @(posedge clk); #1;
    endtask

    task automatic load_prog();
        for (int i = 0; i < prog.size(); i++) begin
            inst_wen  = 1;
            inst_addr = 7'(i);
            inst_data = prog[i];
            m_imem[i] = prog[i];
            @(posedge clk); #1;
        end
        inst_wen = 0;
        prog.delete();
    endtask

    task automatic reset_cpu();
        enb = 0;
        rst = 1;
        #1;
        check("rst_wb", WB_o, 0);
        @(posedge clk); #1;
        rst = 0;
        m_pc = 0;
        for (int i = 0; i < 32; i++) m_x[i] = 0;
    endtask

    function automatic logic [31:0] rand_inst(int idx);
        int k, rd, rs1, rs2, f3, imm;
        k   = $urandom_range(idx <= 59 ? 9 : 7, 0);
        rd  = $urandom_range(7, 0);
        rs1 = $urandom_range(7, 0);
        rs2 = $urandom_range(7, 0);
        f3  = $urandom_range(7, 0);
        imm = $urandom;
        case (k)
            0, 1: begin
                if (f3 == 1) imm = imm & 31;
                else if (f3 == 5) imm = (imm & 31) | ($urandom_range(1, 0) << 10);
                return ei(19, f3, rd, rs1, imm);
            end
            2, 3: return er(f3, (f3 == 0 || f3 == 5) ? 32 * $urandom_range(1, 0) : 0, rd, rs1, rs2);
            4: return eu(55, rd, imm);
            5: return eu(23, rd, imm);
            6: return ei(3, f3 == 3 ? 2 : f3 > 5 ? 4 : f3, rd, rs1, imm);
            7: return es(f3 % 3, rs1, rs2, imm);
            8: return eb(f3 == 2 ? 0 : f3 == 3 ? 1 : f3, rs1, rs2, 8);
            default: return ej(rd, 8);
        endcase
    endfunction

    initial begin
        m_pc = 0;
        for (int i = 0; i < 32; i++) m_x[i] = 0;
        for (int i = 0; i < 256; i++) m_mem[i] = 0;
        @(posedge clk); #1;
        for (int i = 0; i < 128; i++) prog.push_back(32'h13);
        load_prog();
        for (int k = 0; k < 64; k++) prog.push_back(es(2, 0, 0, 4 * k));
        prog.push_back(ej(0, 0));
        load_prog();
        reset_cpu();
        enb = 1;
        repeat (66) step_chk("clr");

        prog = '{ei(19, 0, 1, 0, 5), ei(19, 0, 2, 0, -3), er(0, 0, 3, 1, 2), er(0, 32, 4, 2, 1), ei(19, 5, 5, 2, 'h401)};
        load_prog();
        reset_cpu();
        repeat (3) begin
            @(posedge clk); #1;
            check("idle_wb", WB_o, 0);
            check("idle_pc", dut.pc_q, 0);
        end
        enb = 1;
        step_k("addi5", 32'd5);
        step_k("addim3", 32'hFFFFFFFD);
        step_k("add", 32'd2);
        step_k("sub", 32'hFFFFFFF8);
        step_k("srai", 32'hFFFFFFFE);

        prog = '{eu(55, 1, 'h12345), ei(19, 0, 1, 1, 'h678), es(2, 0, 1, 84), ei(3, 0, 2, 0, 87),
                 ei(3, 1, 3, 0, 86), ei(19, 0, 4, 0, 'h80), es(0, 0, 4, 90), ei(3, 4, 5, 0, 90), ei(3, 0, 6, 0, 90)};
        load_prog();
        reset_cpu();
        enb = 1;
        step_k("lui", 32'h12345000);
        step_k("addi_lo", 32'h12345678);
        step_k("sw", 32'd0);
        check("mem84", dut.DATAMEM.MEM_Data[84], 32'h78);
        check("mem85", dut.DATAMEM.MEM_Data[85], 32'h56);
        check("mem86", dut.DATAMEM.MEM_Data[86], 32'h34);
        check("mem87", dut.DATAMEM.MEM_Data[87], 32'h12);
        step_k("lb87", 32'h12);
        step_k("lh86", 32'h1234);
        step_k("addi80", 32'h80);
        step_k("sb", 32'd0);
        step_k("lbu", 32'h80);
        step_k("lb", 32'hFFFFFF80);

        prog = '{ei(19, 0, 1, 0, -1), ei(19, 0, 2, 0, 1), eb(4, 1, 2, 8), ei(19, 0, 7, 0, 99),
                 ej(8, 8), ei(19, 0, 7, 0, 98), eb(6, 1, 2, 8), eb(0, 2, 2, 8), ei(19, 0, 7, 0, 97),
                 eb(0, 1, 2, 8), ei(19, 0, 9, 0, 49), ei(103, 0, 10, 9, 0), ei(19, 0, 11, 0, 5)};
        load_prog();
        reset_cpu();
        enb = 1;
        for (int i = 0; i < 10; i++) begin
            step_k("br_wb", bwb[i]);
            check("br_pc", dut.pc_q, bpc[i]);
        end

        prog = '{ei(19, 0, 1, 0, 0), ei(19, 0, 2, 0, 1), ei(19, 0, 3, 0, 11), er(0, 0, 1, 1, 2),
                 ei(19, 0, 2, 2, 1), eb(1, 2, 3, -8), es(2, 0, 1, 84), ej(0, 0)};
        load_prog();
        reset_cpu();
        enb = 1;
        repeat (350) step_chk("loop");
        check("sum", {dut.DATAMEM.MEM_Data[87], dut.DATAMEM.MEM_Data[86],
                      dut.DATAMEM.MEM_Data[85], dut.DATAMEM.MEM_Data[84]}, 32'h37);

        prog = '{ei(19, 0, 1, 0, 'h55), es(0, 0, 1, 100)};
        load_prog();
        reset_cpu();
        enb = 1;
        step_k("abort_addi", 32'h55);
        rst = 1;
        #1;
        check("abort_wb", WB_o, 0);
        @(posedge clk); #1;
        rst = 0;
        enb = 0;
        check("abort_mem", dut.DATAMEM.MEM_Data[100], 0);
        check("abort_pc", dut.pc_q, 0);
        check("abort_x1", dut.rf_q[1], 0);
        m_pc = 0;
        for (int i = 0; i < 32; i++) m_x[i] = 0;

        reset_cpu();
        prog = '{ei(19, 0, 0, 0, 7), ei(19, 0, 6, 0, 1), er(0, 0, 7, 0, 6)};
        load_prog();
        enb = 1;
        step_k("x0_wb", 32'd7);
        step_k("x0_read", 32'd1);
        step_k("x0_add", 32'd1);

        for (int r = 0; r < 10; r++) begin
            reset_cpu();
            for (int i = 0; i < 62; i++) prog.push_back(rand_inst(i));
            prog.push_back(ej(0, 0));
            prog.push_back(32'h13);
            load_prog();
            enb = 1;
            repeat (70) step_chk("rand");
            enb = 0;
            for (int i = 1; i < 8; i++) check("rand_x", dut.rf_q[i], m_x[i]);
        end
        for (int a = 0; a < 256; a++) check("rand_mem", dut.DATAMEM.MEM_Data[a], m_mem[a]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
